// File: rtl/equal_run_detector.sv
// rtl/equal_run_detector.sv - Moore detector: z=1 while the last RUN_LEN samples had w1==w2
module equal_run_detector #(
    parameter int RUN_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic w1,
    input  logic w2,
    output logic z
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             same;

    assign same = ~(w1 ^ w2);

    always_comb begin
        cnt_next = '0;
        if (same) begin
            // Saturate so a long run keeps z high without wrapping back to S0.
            cnt_next = (cnt == RUN_MAX) ? RUN_MAX : cnt + CNT_ONE;
        end
    end

    // z is registered from the next state, so it equals (cnt == RUN_LEN) at all times
    // while never depending combinationally on w1/w2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            z   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            z   <= (cnt_next == RUN_MAX);
        end
    end

endmodule

// File: tb/tb_equal_run_detector.sv
// tb/tb_equal_run_detector.sv - scoreboard bench for equal_run_detector against a sample-history model
module tb_equal_run_detector;

    localparam int RUN_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w1  = 1'b0;
    logic w2  = 1'b0;
    logic z;

    int checks = 0;
    int fails  = 0;

    bit exp_q[$];
    bit hist[$];

    equal_run_detector #(.RUN_LEN(RUN_LEN)) dut (
        .clk(clk),
        .rst(rst),
        .w1 (w1),
        .w2 (w2),
        .z  (z)
    );

    always #5 clk = ~clk;

    // Reference: z after an edge is 1 iff the newest RUN_LEN samples since reset were all equal.
    function automatic bit model_step(input bit a, input bit b);
        bit all_eq;
        hist.push_back(a == b);
        if (hist.size() > RUN_LEN) void'(hist.pop_front());
        all_eq = (hist.size() == RUN_LEN);
        foreach (hist[i]) if (!hist[i]) all_eq = 1'b0;
        return all_eq;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: z=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit a, input bit b);
        @(negedge clk);
        w1 = a;
        w2 = b;
        exp_q.push_back(model_step(a, b));
    endtask

    // Release on a negedge and present a mismatch in the same step so every
    // un-reset edge has exactly one expectation queued.
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        w1  = 1'b0;
        w2  = 1'b1;
        hist.delete();
        exp_q.push_back(model_step(1'b0, 1'b1));
    endtask

    always @(posedge clk) begin
        #2;
        if (rst) begin
            check("reset_hold", z, 1'b0);
        end else if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_underflow: z=%b expected <none> at %0t", z, $time);
        end else begin
            check("scoreboard", z, exp_q.pop_front());
        end
    end

    initial begin
        #1;
        check("reset_initial", z, 1'b0);
        repeat (2) @(negedge clk);
        release_reset();

        // 01 held: never equal
        repeat (3) drive(1'b0, 1'b1);

        // Mixed 11/00 run, then saturation, mismatch, mismatches
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b1);

        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);

        // Runs one short of RUN_LEN never assert
        repeat (3) begin
            repeat (RUN_LEN - 1) drive(1'b1, 1'b1);
            drive(1'b1, 1'b0);
        end

        // Async reset between edges while z=1
        repeat (RUN_LEN) drive(1'b0, 1'b0);
        @(posedge clk);
        #3;
        check("pre_async_reset", z, 1'b1);
        rst = 1'b1;
        #1;
        check("async_reset_immediate", z, 1'b0);
        repeat (2) @(negedge clk);
        release_reset();
        repeat (RUN_LEN - 1) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Random traffic biased toward equal pairs so long runs occur
        for (int i = 0; i < 2000; i++) begin
            bit a, b;
            a = $urandom_range(0, 1);
            b = ($urandom_range(0, 99) < 80) ? a : ~a;
            drive(a, b);
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                check("async_reset_random", z, 1'b0);
                release_reset();
            end
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
